// File: rtl/cmd_parser_if.sv
// Host byte stream, MREQ request and write-payload signals between the command parser and its neighbours.
// The parser drives through the master modport; the host/Wishbone master side uses slave.
interface cmd_parser_if;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned ADDR_W = 32;

   logic              rx_valid;
   logic [BYTE_W-1:0] rx_data;
   logic              rx_ready;
   logic              mreq_valid;
   logic              mreq_ready;
   logic              mreq_wr;
   logic [1:0]        mreq_wsize;
   logic              mreq_aincr;
   logic [BYTE_W-1:0] mreq_wcount;
   logic [ADDR_W-1:0] mreq_addr;
   logic              data_valid;
   logic [BYTE_W-1:0] data;
   logic              data_ready;
   logic              err;

   modport master (
      input  rx_valid, rx_data, mreq_ready, data_ready,
      output rx_ready, mreq_valid, mreq_wr, mreq_wsize, mreq_aincr,
             mreq_wcount, mreq_addr, data_valid, data, err
   );

   modport slave (
      output rx_valid, rx_data, mreq_ready, data_ready,
      input  rx_ready, mreq_valid, mreq_wr, mreq_wsize, mreq_aincr,
             mreq_wcount, mreq_addr, data_valid, data, err
   );
endinterface

// File: rtl/cmd_parser.sv
// Host-command front end: parses a 6-byte header into one MREQ and forwards
// write payload bytes to the command master while that MREQ is in flight.
module cmd_parser #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic            clk,
   input  logic            rst,
   cmd_parser_if.master    bus
);
   localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned PAY_W  = 11;
   localparam logic [3:0]  SYNC   = 4'hA;

   typedef enum logic [1:0] {ST_CTRL, ST_WCNT, ST_ADDR, ST_MREQ} state_t;

   state_t            state, state_nx;
   logic              err_nx;
   logic              wr_q, aincr_q;
   logic [1:0]        wsize_q;
   logic [7:0]        wcount_q;
   logic [31:0]       addr_q;
   logic [1:0]        byte_idx;
   logic [IDLE_W-1:0] idle_cnt;
   logic [PAY_W-1:0]  pay_left;
   logic [PAY_W-1:0]  wc_p1;
   logic [PAY_W-1:0]  pay_init;
   logic              mreq_valid_q;
   logic              err_q;
   logic              pay_active;
   logic              rx_ready_c;
   logic              sync_ok;
   logic              timeout_hit;
   logic              pay_xfer;

   assign sync_ok     = (bus.rx_data[3:0] == SYNC);
   assign pay_active  = (state == ST_MREQ) && (pay_left != '0);
   assign pay_xfer    = pay_active && bus.rx_valid && bus.data_ready;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                        (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

   // Payload length in bytes: (wcount + 1) words of 1/2/4 bytes; wsize 3 counts as bytes.
   always_comb begin
      wc_p1 = PAY_W'(wcount_q) + PAY_W'(1);
      case (wsize_q)
         2'd1:    pay_init = wc_p1 << 1;
         2'd2:    pay_init = wc_p1 << 2;
         default: pay_init = wc_p1;
      endcase
   end

   // Header bytes are always taken; during a write MREQ the master's ready gates the host.
   always_comb begin
      rx_ready_c = 1'b0;
      case (state)
         ST_CTRL, ST_WCNT, ST_ADDR: rx_ready_c = 1'b1;
         ST_MREQ:                   rx_ready_c = pay_active && bus.data_ready;
         default:                   rx_ready_c = 1'b0;
      endcase
   end

   assign bus.rx_ready    = rx_ready_c;
   assign bus.data_valid  = pay_active && bus.rx_valid;
   assign bus.data        = pay_active ? bus.rx_data : '0;
   assign bus.mreq_valid  = mreq_valid_q;
   assign bus.mreq_wr     = wr_q;
   assign bus.mreq_wsize  = wsize_q;
   assign bus.mreq_aincr  = aincr_q;
   assign bus.mreq_wcount = wcount_q;
   assign bus.mreq_addr   = addr_q;
   assign bus.err         = err_q;

   // Next-state logic
   always_comb begin
      state_nx = state;
      err_nx   = 1'b0;
      case (state)
         ST_CTRL: begin
            if (bus.rx_valid) begin
               if (sync_ok) state_nx = ST_WCNT;
               else         err_nx   = 1'b1;
            end
         end
         ST_WCNT: begin
            if (bus.rx_valid) begin
               state_nx = ST_ADDR;
            end else if (timeout_hit) begin
               state_nx = ST_CTRL;
               err_nx   = 1'b1;
            end
         end
         ST_ADDR: begin
            if (bus.rx_valid) begin
               if (byte_idx == 2'd3) state_nx = ST_MREQ;
            end else if (timeout_hit) begin
               state_nx = ST_CTRL;
               err_nx   = 1'b1;
            end
         end
         ST_MREQ: begin
            if (bus.mreq_ready) state_nx = ST_CTRL;
         end
         default: state_nx = ST_CTRL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_CTRL;
         err_q        <= 1'b0;
         mreq_valid_q <= 1'b0;
      end else begin
         state        <= state_nx;
         err_q        <= err_nx;
         mreq_valid_q <= (state_nx == ST_MREQ);
      end
   end

   // Header field capture, payload countdown and inter-byte idle counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q     <= 1'b0;
         aincr_q  <= 1'b0;
         wsize_q  <= '0;
         wcount_q <= '0;
         addr_q   <= '0;
         byte_idx <= '0;
         pay_left <= '0;
         idle_cnt <= '0;
      end else begin
         case (state)
            ST_CTRL: begin
               if (bus.rx_valid && sync_ok) begin
                  wr_q    <= bus.rx_data[7];
                  aincr_q <= bus.rx_data[6];
                  wsize_q <= bus.rx_data[5:4];
               end
            end
            ST_WCNT: begin
               if (bus.rx_valid) begin
                  wcount_q <= bus.rx_data;
                  byte_idx <= '0;
               end
            end
            ST_ADDR: begin
               if (bus.rx_valid) begin
                  addr_q[{byte_idx, 3'b000} +: 8] <= bus.rx_data;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) pay_left <= wr_q ? pay_init : '0;
               end
            end
            ST_MREQ: begin
               if (bus.mreq_ready)  pay_left <= '0;
               else if (pay_xfer)   pay_left <= pay_left - PAY_W'(1);
            end
            default: ;
         endcase

         if ((state == ST_WCNT || state == ST_ADDR) && !bus.rx_valid && state_nx == state)
            idle_cnt <= idle_cnt + IDLE_W'(1);
         else
            idle_cnt <= '0;
      end
   end
endmodule

// File: tb/tb_cmd_parser.sv
// Directed bench for cmd_parser: header parsing, payload pass-through,
// sync errors, inter-byte timeout, backpressure and asynchronous reset.
module tb_cmd_parser;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   logic [7:0] fwd_q[$];

   cmd_parser_if bus ();

   cmd_parser #(.TIMEOUT_CYCLES(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Record every payload byte handed to the master.
   always @(posedge clk)
      if (bus.data_valid && bus.data_ready) fwd_q.push_back(bus.data);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int w;
      w = 0;
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      #1;
      while (!bus.rx_ready && w < 50) begin
         tick();
         w++;
      end
      check("send_stall", 32'(w >= 50), 32'd0);
      tick();
      bus.rx_valid = 1'b0;
   endtask

   task automatic release_mreq();
      bus.mreq_ready = 1'b1;
      tick();
      bus.mreq_ready = 1'b0;
   endtask

   initial begin
      int n;
      int cnt;
      int cyc;
      logic seen_mv;

      rst = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data = 8'h00;
      bus.mreq_ready = 1'b0;
      bus.data_ready = 1'b0;
      repeat (3) tick();

      check("rst_rx_ready",   32'(bus.rx_ready),   32'd1);
      check("rst_mreq_valid", 32'(bus.mreq_valid), 32'd0);
      check("rst_data_valid", 32'(bus.data_valid), 32'd0);
      check("rst_err",        32'(bus.err),        32'd0);
      check("rst_addr",       bus.mreq_addr,       32'd0);
      rst = 1'b0;
      tick();

      // T1: write, 4-byte words, wcount 1, addr 0x10 -> 8 payload bytes
      send_byte(8'hAA); send_byte(8'h01); send_byte(8'h10);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      check("t1_mreq_valid", 32'(bus.mreq_valid), 32'd1);
      check("t1_wr",         32'(bus.mreq_wr),    32'd1);
      check("t1_wsize",      32'(bus.mreq_wsize), 32'd2);
      check("t1_aincr",      32'(bus.mreq_aincr), 32'd0);
      check("t1_wcount",     32'(bus.mreq_wcount), 32'd1);
      check("t1_addr",       bus.mreq_addr,       32'h10);
      fwd_q.delete();
      bus.data_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.rx_valid = 1'b1;
         bus.rx_data  = 8'(8'h10 + i);
         #1;
         check("t1_data_valid", 32'(bus.data_valid), 32'd1);
         check("t1_data",       32'(bus.data),       32'(8'h10 + i));
         tick();
      end
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'hEE;
      #1;
      check("t1_excess_ready", 32'(bus.rx_ready),   32'd0);
      check("t1_excess_valid", 32'(bus.data_valid), 32'd0);
      tick();
      check("t1_excess_hold",  32'(bus.rx_ready),   32'd0);
      check("t1_mreq_held",    32'(bus.mreq_valid), 32'd1);
      bus.rx_valid = 1'b0;
      check("t1_fwd_count", 32'(fwd_q.size()), 32'd8);
      for (int i = 0; i < 8; i++)
         if (i < fwd_q.size()) check("t1_fwd_byte", 32'(fwd_q[i]), 32'(8'h10 + i));
      release_mreq();
      check("t1_done_valid", 32'(bus.mreq_valid), 32'd0);
      check("t1_done_ready", 32'(bus.rx_ready),   32'd1);

      // T2: read, 2-byte words, wcount 3, addr 0x01020304
      send_byte(8'h1A); send_byte(8'h03); send_byte(8'h04);
      send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
      check("t2_mreq_valid", 32'(bus.mreq_valid),  32'd1);
      check("t2_wr",         32'(bus.mreq_wr),     32'd0);
      check("t2_wsize",      32'(bus.mreq_wsize),  32'd1);
      check("t2_wcount",     32'(bus.mreq_wcount), 32'd3);
      check("t2_addr",       bus.mreq_addr,        32'h01020304);
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h85;
      bus.data_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t2_rx_blocked",  32'(bus.rx_ready),   32'd0);
         check("t2_no_payload",  32'(bus.data_valid), 32'd0);
         tick();
      end
      release_mreq();
      check("t2_next_ready", 32'(bus.rx_ready),   32'd1);
      check("t2_done_valid", 32'(bus.mreq_valid), 32'd0);
      check("t2_no_err",     32'(bus.err),        32'd0);

      // T3: 0x85 has a bad sync nibble; 0x2A is a valid CTRL
      tick();
      check("t3_err_pulse", 32'(bus.err), 32'd1);
      bus.rx_data = 8'h2A;
      tick();
      check("t3_err_clear", 32'(bus.err), 32'd0);
      bus.rx_valid = 1'b0;
      send_byte(8'h00); send_byte(8'h78); send_byte(8'h56);
      send_byte(8'h34); send_byte(8'h12);
      check("t3_mreq_valid", 32'(bus.mreq_valid), 32'd1);
      check("t3_wsize",      32'(bus.mreq_wsize), 32'd2);
      check("t3_addr",       bus.mreq_addr,       32'h12345678);
      release_mreq();
      release_mreq();
      check("t3_stray_ready", 32'(bus.mreq_valid), 32'd0);

      // T4: header stalls after WCOUNT; timeout after 16 idle cycles
      send_byte(8'h0A); send_byte(8'h02);
      n = 0;
      seen_mv = 1'b0;
      while (!bus.err && n < 40) begin
         tick();
         n++;
         if (bus.mreq_valid) seen_mv = 1'b1;
      end
      check("t4_timeout_cycle", 32'(n),          32'd16);
      check("t4_back_in_ctrl",  32'(bus.rx_ready), 32'd1);
      check("t4_no_mreq",       32'(seen_mv),    32'd0);
      tick();
      check("t4_err_pulse_end", 32'(bus.err),    32'd0);

      // T5: write with master backpressure toggling 1/0
      send_byte(8'hAA); send_byte(8'h01); send_byte(8'h20);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      check("t5_addr", bus.mreq_addr, 32'h20);
      fwd_q.delete();
      cnt = 0;
      cyc = 0;
      while (cnt < 8 && cyc < 40) begin
         bus.rx_valid   = 1'b1;
         bus.rx_data    = 8'(8'h30 + cnt);
         bus.data_ready = (cyc % 2 == 0);
         #1;
         if (!bus.data_ready) check("t5_stalled_ready", 32'(bus.rx_ready), 32'd0);
         check("t5_data_valid", 32'(bus.data_valid), 32'd1);
         tick();
         if (bus.data_ready) cnt++;
         cyc++;
      end
      check("t5_xfer_budget", 32'(cnt), 32'd8);
      bus.data_ready = 1'b1;
      bus.rx_data    = 8'hFF;
      #1;
      check("t5_done_ready", 32'(bus.rx_ready),   32'd0);
      check("t5_done_valid", 32'(bus.data_valid), 32'd0);
      bus.rx_valid = 1'b0;
      check("t5_fwd_count", 32'(fwd_q.size()), 32'd8);
      for (int i = 0; i < 8; i++)
         if (i < fwd_q.size()) check("t5_fwd_byte", 32'(fwd_q[i]), 32'(8'h30 + i));
      tick();
      release_mreq();

      // T6: async reset in ST_ADDR, then in the middle of a payload
      send_byte(8'hAA); send_byte(8'h01); send_byte(8'h10); send_byte(8'h00);
      #2;
      rst = 1'b1;
      #1;
      check("t6a_rx_ready", 32'(bus.rx_ready),    32'd1);
      check("t6a_mreq",     32'(bus.mreq_valid),  32'd0);
      check("t6a_addr",     bus.mreq_addr,        32'd0);
      check("t6a_wcount",   32'(bus.mreq_wcount), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      send_byte(8'hAA); send_byte(8'h00); send_byte(8'h40);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      check("t6b_mreq_valid", 32'(bus.mreq_valid), 32'd1);
      bus.data_ready = 1'b1;
      bus.rx_valid   = 1'b1;
      bus.rx_data    = 8'h71;
      tick();
      bus.rx_data    = 8'h77;
      #2;
      rst = 1'b1;
      #1;
      check("t6b_data_valid", 32'(bus.data_valid), 32'd0);
      check("t6b_data",       32'(bus.data),       32'd0);
      check("t6b_rx_ready",   32'(bus.rx_ready),   32'd1);
      check("t6b_mreq",       32'(bus.mreq_valid), 32'd0);
      bus.rx_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      send_byte(8'h1A); send_byte(8'h00); send_byte(8'hEF);
      send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
      check("t6c_mreq_valid", 32'(bus.mreq_valid), 32'd1);
      check("t6c_wr",         32'(bus.mreq_wr),    32'd0);
      check("t6c_addr",       bus.mreq_addr,       32'hDEADBEEF);
      release_mreq();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
